// File: rtl/chargen_usb_tx.sv
// -----------------------------------------------------------------------------
// chargen_usb_tx
//
// Byte buffer and FT245-style USB FIFO write engine placed directly after a
// chargen character source. The block paces chargen with src_n_cs, captures
// every byte chargen presents, buffers the bytes in a DEPTH-entry FIFO and
// writes them one at a time to the external USB FIFO with a usb_wr strobe
// that is only started while usb_n_txe reports room.
//
// Parameters
//    DEPTH      FIFO entries, power of two, >= 2
//    WR_CYCLES  width of the usb_wr high pulse in clocks, >= 1
//
// Ports
//    clk        system clock, all logic on the rising edge
//    n_rst      synchronous active-low reset
//    en         allows new bytes to be requested from chargen
//    src_data   byte presented by chargen
//    src_n_wr   chargen data-valid, active low
//    src_n_cs   request/advance to chargen, active low, registered
//    usb_data   byte driven to the external USB FIFO
//    usb_wr     write strobe, external FIFO latches on its falling edge
//    usb_n_txe  room available from the USB FIFO, active low, asynchronous
//    level      current FIFO occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module chargen_usb_tx #(
   parameter int DEPTH     = 16,
   parameter int WR_CYCLES = 2
) (
   input  logic                       clk,
   input  logic                       n_rst,
   input  logic                       en,
   input  logic [7:0]                 src_data,
   input  logic                       src_n_wr,
   output logic                       src_n_cs,
   output logic [7:0]                 usb_data,
   output logic                       usb_wr,
   input  logic                       usb_n_txe,
   output logic [$clog2(DEPTH+1)-1:0] level
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);
   localparam int CW = $clog2(WR_CYCLES + 2);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      HOLD,
      RECOVER
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [CW-1:0]   cnt;
   logic [7:0]      mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic            txe_meta;
   logic            txe_s;
   logic            push;
   logic            pop;
   logic            load;
   logic [LW-1:0]   count_next;

   // Next-state logic for the write engine together with the push/pop
   // decisions. A push is simply the handshake seen at this edge; because
   // src_n_cs is computed from the occupancy after this edge, a push can never
   // land on a full FIFO. The pop happens on the last strobe cycle so the
   // external FIFO has already seen the whole pulse before the entry is freed.
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      load       = 1'b0;
      push       = !src_n_cs && !src_n_wr;
      case (state)
         IDLE: begin
            if (level != '0 && !txe_s) begin
               state_next = SETUP;
               load       = 1'b1;
            end
         end
         SETUP: begin
            state_next = STROBE;
         end
         STROBE: begin
            if (cnt == CW'(WR_CYCLES - 1)) begin
               state_next = HOLD;
               pop        = 1'b1;
            end
         end
         HOLD: begin
            state_next = RECOVER;
         end
         RECOVER: begin
            if (cnt == CW'(1)) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      count_next = level + {{(LW-1){1'b0}}, push} - {{(LW-1){1'b0}}, pop};
   end

   // State register, per-state cycle counter, the two-flop usb_n_txe
   // synchroniser and the registered USB outputs. The synchroniser resets to
   // "no room" so nothing is written until the external FIFO has been seen
   // asserting usb_n_txe after reset. usb_data is only reloaded when a new
   // byte is started, so it stays stable through SETUP, STROBE and HOLD.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state    <= IDLE;
         cnt      <= '0;
         txe_meta <= 1'b1;
         txe_s    <= 1'b1;
         usb_wr   <= 1'b0;
         usb_data <= 8'h00;
      end else begin
         txe_meta <= usb_n_txe;
         txe_s    <= txe_meta;
         state    <= state_next;
         cnt      <= (state_next != state) ? '0 : cnt + CW'(1);
         usb_wr   <= (state_next == STROBE);
         if (load) begin
            usb_data <= mem[rd_ptr];
         end
      end
   end

   // FIFO bookkeeping and the chargen request. Pointers wrap naturally because
   // DEPTH is a power of two. The request looks at the occupancy after this
   // edge so a slot freed by a pop is offered back to chargen on the very next
   // cycle, giving one src_n_cs low pulse per pop once the FIFO is full.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         src_n_cs <= 1'b1;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         level    <= count_next;
         src_n_cs <= !(en && (count_next < LW'(DEPTH)));
      end
   end

   // Storage array, kept free of reset so it can map onto plain RAM.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= src_data;
      end
   end

endmodule

// File: tb/tb_chargen_usb_tx.sv
// -----------------------------------------------------------------------------
// tb_chargen_usb_tx
//
// Directed bench for chargen_usb_tx. A small behavioural chargen drives the
// source side; bytes are collected from the falling edges of usb_wr and
// compared against the character sequence chargen is known to produce.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_chargen_usb_tx;

   logic       clk;
   logic       n_rst;
   logic       en;
   logic [7:0] src_data;
   logic       src_n_wr;
   logic       src_n_cs;
   logic [7:0] usb_data;
   logic       usb_wr;
   logic       usb_n_txe;
   logic [4:0] level;

   logic [7:0] last_char;
   int         vectors;
   int         miscompares;
   int         cyc;
   int         c0;
   int         max_level;
   logic       prev_wr;
   logic [7:0] out_q[$];
   int         fall_cyc[$];

   chargen_usb_tx #(
      .DEPTH     (16),
      .WR_CYCLES (2)
   ) dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .en        (en),
      .src_data  (src_data),
      .src_n_wr  (src_n_wr),
      .src_n_cs  (src_n_cs),
      .usb_data  (usb_data),
      .usb_wr    (usb_wr),
      .usb_n_txe (usb_n_txe),
      .level     (level)
   );

   // Free-running 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural chargen: after reset it shows 'a' with n_wr high; each edge
   // with n_cs low advances to the next character (wrapping after last_char)
   // and marks the data valid.
   always @(posedge clk) begin
      if (!n_rst) begin
         src_data <= 8'h61;
         src_n_wr <= 1'b1;
      end else if (!src_n_cs) begin
         src_data <= (src_data == last_char) ? 8'h61 : src_data + 8'h01;
         src_n_wr <= 1'b0;
      end
   end

   // k-th byte captured after reset: chargen's first character is skipped.
   function automatic logic [7:0] exp_char(int k, logic [7:0] last);
      int span;
      span = int'(last) - 'h61 + 1;
      return 8'('h61 + ((k + 1) % span));
   endfunction

   // Advance to the next falling clock edge and record any usb_wr fall.
   task automatic step();
      @(negedge clk);
      cyc++;
      if (prev_wr && !usb_wr) begin
         out_q.push_back(usb_data);
         fall_cyc.push_back(cyc);
      end
      prev_wr = usb_wr;
      if (int'(level) > max_level) max_level = int'(level);
   endtask

   // Reset for three cycles, then release; c0 marks the release point.
   task automatic apply_reset(input logic txe, input logic [7:0] last);
      usb_n_txe = txe;
      last_char = last;
      en        = 1'b1;
      n_rst     = 1'b0;
      repeat (3) step();
      out_q.delete();
      fall_cyc.delete();
      prev_wr   = 1'b0;
      max_level = 0;
      n_rst     = 1'b1;
      c0        = cyc;
   endtask

   task automatic test_reset();
      usb_n_txe = 1'b0;
      last_char = 8'h63;
      en        = 1'b1;
      n_rst     = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         vectors++;
         if (src_n_cs !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_src_n_cs: got %b expected 1", src_n_cs);
         end
         vectors++;
         if (usb_wr !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_usb_wr: got %b expected 0", usb_wr);
         end
         vectors++;
         if (usb_data !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_usb_data: got %h expected 00", usb_data);
         end
         vectors++;
         if (level !== 5'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_level: got %0d expected 0", level);
         end
      end
      n_rst = 1'b1;
      step();
      vectors++;
      if (src_n_cs !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL release_src_n_cs: got %b expected 0", src_n_cs);
      end
   endtask

   task automatic test_capture_order();
      int n;
      apply_reset(1'b0, 8'h63);
      n = 0;
      while (out_q.size() < 5 && n < 80) begin
         step();
         n++;
      end
      vectors++;
      if (out_q.size() < 5) begin
         miscompares++;
         $display("[TB] FAIL capture_count: got %0d expected 5", out_q.size());
      end else begin
         vectors++;
         if (fall_cyc[0] !== c0 + 7) begin
            miscompares++;
            $display("[TB] FAIL capture_first_fall: got cycle %0d expected %0d",
                     fall_cyc[0] - c0, 7);
         end
         for (int k = 0; k < 5; k++) begin
            vectors++;
            if (out_q[k] !== exp_char(k, 8'h63)) begin
               miscompares++;
               $display("[TB] FAIL capture_byte%0d: got %h expected %h",
                        k, out_q[k], exp_char(k, 8'h63));
            end
         end
         for (int k = 1; k < 5; k++) begin
            vectors++;
            if (fall_cyc[k] - fall_cyc[k-1] !== 7) begin
               miscompares++;
               $display("[TB] FAIL capture_spacing%0d: got %0d expected 7",
                        k, fall_cyc[k] - fall_cyc[k-1]);
            end
         end
      end
   endtask

   task automatic test_fill();
      int n;
      int cs_low;
      apply_reset(1'b1, 8'h7a);
      for (int i = 0; i < 25; i++) begin
         step();
         if (level == 5'd16) begin
            vectors++;
            if (src_n_cs !== 1'b1) begin
               miscompares++;
               $display("[TB] FAIL fill_cs_at_full: got %b expected 1", src_n_cs);
            end
         end
      end
      vectors++;
      if (level !== 5'd16) begin
         miscompares++;
         $display("[TB] FAIL fill_level: got %0d expected 16", level);
      end
      vectors++;
      if (out_q.size() !== 0) begin
         miscompares++;
         $display("[TB] FAIL fill_no_write: got %0d writes expected 0", out_q.size());
      end
      usb_n_txe = 1'b0;
      n = 0;
      cs_low = 0;
      while (out_q.size() < 16 && n < 140) begin
         step();
         if (!src_n_cs) cs_low++;
         n++;
      end
      vectors++;
      if (out_q.size() !== 16) begin
         miscompares++;
         $display("[TB] FAIL fill_drain_count: got %0d expected 16", out_q.size());
      end
      for (int k = 0; k < out_q.size(); k++) begin
         vectors++;
         if (out_q[k] !== exp_char(k, 8'h7a)) begin
            miscompares++;
            $display("[TB] FAIL fill_byte%0d: got %h expected %h",
                     k, out_q[k], exp_char(k, 8'h7a));
         end
      end
      vectors++;
      if (cs_low !== 16) begin
         miscompares++;
         $display("[TB] FAIL fill_cs_pulses: got %0d expected 16", cs_low);
      end
      vectors++;
      if (max_level > 16) begin
         miscompares++;
         $display("[TB] FAIL fill_max_level: got %0d expected <=16", max_level);
      end
   endtask

   task automatic test_wrap();
      int n;
      apply_reset(1'b0, 8'h7a);
      n = 0;
      while (out_q.size() < 48 && n < 420) begin
         step();
         n++;
      end
      vectors++;
      if (out_q.size() !== 48) begin
         miscompares++;
         $display("[TB] FAIL wrap_count: got %0d expected 48", out_q.size());
      end
      for (int k = 0; k < out_q.size(); k++) begin
         vectors++;
         if (out_q[k] !== exp_char(k, 8'h7a)) begin
            miscompares++;
            $display("[TB] FAIL wrap_byte%0d: got %h expected %h",
                     k, out_q[k], exp_char(k, 8'h7a));
         end
      end
      vectors++;
      if (max_level > 16) begin
         miscompares++;
         $display("[TB] FAIL wrap_max_level: got %0d expected <=16", max_level);
      end
   endtask

   task automatic test_txe_during_strobe();
      int n;
      int hi;
      int rises;
      apply_reset(1'b0, 8'h7a);
      n = 0;
      while (usb_wr !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      vectors++;
      if (usb_wr !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL txe_first_strobe: got %b expected 1", usb_wr);
      end
      usb_n_txe = 1'b1;
      hi = 1;
      for (int i = 0; i < 4; i++) begin
         step();
         if (usb_wr) hi++;
      end
      vectors++;
      if (hi !== 2) begin
         miscompares++;
         $display("[TB] FAIL txe_pulse_width: got %0d expected 2", hi);
      end
      vectors++;
      if (out_q.size() !== 1 || out_q[0] !== 8'h62) begin
         miscompares++;
         $display("[TB] FAIL txe_inflight_byte: got %0d bytes expected 1 of 62",
                  out_q.size());
      end
      rises = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (usb_wr) rises++;
      end
      vectors++;
      if (rises !== 0) begin
         miscompares++;
         $display("[TB] FAIL txe_blocked: got %0d strobe cycles expected 0", rises);
      end
      usb_n_txe = 1'b0;
      n = 0;
      while (usb_wr !== 1'b1 && n < 10) begin
         step();
         n++;
      end
      vectors++;
      if (n !== 4) begin
         miscompares++;
         $display("[TB] FAIL txe_resume_latency: got %0d expected 4", n);
      end
      n = 0;
      while (out_q.size() < 2 && n < 10) begin
         step();
         n++;
      end
      vectors++;
      if (out_q.size() < 2 || out_q[1] !== 8'h63) begin
         miscompares++;
         $display("[TB] FAIL txe_resume_byte: got %0d bytes expected second 63",
                  out_q.size());
      end
   endtask

   task automatic test_en_drop();
      int n;
      apply_reset(1'b1, 8'h7a);
      n = 0;
      while (level !== 5'd4 && n < 20) begin
         step();
         n++;
      end
      en = 1'b0;
      step();
      vectors++;
      if (level !== 5'd5) begin
         miscompares++;
         $display("[TB] FAIL endrop_level: got %0d expected 5", level);
      end
      vectors++;
      if (src_n_cs !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL endrop_cs: got %b expected 1", src_n_cs);
      end
      repeat (5) step();
      usb_n_txe = 1'b0;
      repeat (55) step();
      vectors++;
      if (out_q.size() !== 5) begin
         miscompares++;
         $display("[TB] FAIL endrop_strobes: got %0d expected 5", out_q.size());
      end
      for (int k = 0; k < out_q.size(); k++) begin
         vectors++;
         if (out_q[k] !== exp_char(k, 8'h7a)) begin
            miscompares++;
            $display("[TB] FAIL endrop_byte%0d: got %h expected %h",
                     k, out_q[k], exp_char(k, 8'h7a));
         end
      end
      vectors++;
      if (level !== 5'd0) begin
         miscompares++;
         $display("[TB] FAIL endrop_final_level: got %0d expected 0", level);
      end
      vectors++;
      if (usb_wr !== 1'b0 || src_n_cs !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL endrop_idle: got wr=%b cs=%b expected wr=0 cs=1",
                  usb_wr, src_n_cs);
      end
      en = 1'b1;
   endtask

   task automatic test_reset_mid_strobe();
      int n;
      apply_reset(1'b0, 8'h7a);
      n = 0;
      while (usb_wr !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      vectors++;
      if (level === 5'd0) begin
         miscompares++;
         $display("[TB] FAIL midrst_prelevel: got %0d expected nonzero", level);
      end
      n_rst = 1'b0;
      step();
      vectors++;
      if (usb_wr !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL midrst_usb_wr: got %b expected 0", usb_wr);
      end
      vectors++;
      if (level !== 5'd0) begin
         miscompares++;
         $display("[TB] FAIL midrst_level: got %0d expected 0", level);
      end
      vectors++;
      if (src_n_cs !== 1'b1 || usb_data !== 8'h00) begin
         miscompares++;
         $display("[TB] FAIL midrst_outputs: got cs=%b data=%h expected cs=1 data=00",
                  src_n_cs, usb_data);
      end
      n_rst = 1'b1;
      step();
      vectors++;
      if (src_n_cs !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL midrst_release_cs: got %b expected 0", src_n_cs);
      end
   endtask

   // Scenario sequence, each one starting from its own reset.
   initial begin
      vectors     = 0;
      miscompares = 0;
      cyc         = 0;
      c0          = 0;
      max_level   = 0;
      prev_wr     = 1'b0;
      n_rst       = 1'b0;
      en          = 1'b0;
      usb_n_txe   = 1'b1;
      last_char   = 8'h63;
      test_reset();
      test_capture_order();
      test_fill();
      test_wrap();
      test_txe_during_strobe();
      test_en_drop();
      test_reset_mid_strobe();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
